// File: rtl/bus_stream_fifo.sv
// bus_stream_fifo
//   Bus slave that buffers a 32-bit streaming source in block RAM and serves
//   the words to the bus master through BUS_RD bursts on a data window.
//   Register map (byte offsets from BASEADDR):
//     0x0  read: {24'b0, VERSION}; write (any data): soft reset
//     0x4  read: fill count in words
//     0x8  read: overflow counter (0 when the counter is not built)
//   Anything from DATA_OFFSET up to HIGHADDR is the pop window.
//   Read data appears on BUS_DATA one cycle after the BUS_RD cycle.
//
//   Optional feature macro: BUS_STREAM_FIFO_OVF_CNT_EN
//     defined     -> 32-bit saturating overflow counter at 0x8
//     not defined -> no counter logic, 0x8 reads 0
//
//   Stream handshake: FIFO_WRITE is a one-cycle "word valid" qualifier.
//   A word is accepted on any edge where FIFO_WRITE is high and the FIFO is
//   not full; with the FIFO full the word is dropped, so the source must
//   watch FIFO_FULL and stall.

module bus_stream_fifo #(
  parameter int                   ABUSWIDTH   = 32,
  parameter logic [ABUSWIDTH-1:0] BASEADDR    = 'h8000,
  parameter logic [ABUSWIDTH-1:0] HIGHADDR    = 'h8FFF,
  parameter logic [ABUSWIDTH-1:0] DATA_OFFSET = 'h100,
  parameter int                   DEPTH       = 1024
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST,
  input  logic [ABUSWIDTH-1:0] BUS_ADD,
  inout  wire  [31:0]          BUS_DATA,
  input  logic                 BUS_RD,
  input  logic                 BUS_WR,
  input  logic                 FIFO_WRITE,
  input  logic [31:0]          FIFO_DATA,
  output logic                 FIFO_FULL,
  output logic                 FIFO_EMPTY
);

  // Address bits into the RAM, plus one wrap bit in the pointers so that
  // full (count == DEPTH) and empty (count == 0) are distinguishable.
  localparam int             AW      = $clog2(DEPTH);
  localparam int             PW      = AW + 1;
  localparam logic [PW-1:0]  DEPTH_W = PW'(DEPTH);
  localparam logic [7:0]     VERSION = 8'd1;

  localparam logic [ABUSWIDTH-1:0] REG_VERSION = ABUSWIDTH'(0);
  localparam logic [ABUSWIDTH-1:0] REG_COUNT   = ABUSWIDTH'(4);
  localparam logic [ABUSWIDTH-1:0] REG_OVF     = ABUSWIDTH'(8);

  // ---------------------------------------------------------------------------
  // Storage and state
  // ---------------------------------------------------------------------------
  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [31:0]   rd_data;
  logic          drive_q;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [ABUSWIDTH-1:0] rel;
  logic                 in_range;
  logic                 in_data;
  logic                 in_regs;
  logic                 rd_access;
  logic                 pop_req;
  logic                 soft_rst;

  assign rel       = BUS_ADD - BASEADDR;
  assign in_range  = (BUS_ADD >= BASEADDR) && (BUS_ADD <= HIGHADDR);
  assign in_data   = in_range && (rel >= DATA_OFFSET);
  assign in_regs   = in_range && (rel < DATA_OFFSET);

  // A write cycle always wins over a read strobe: no pop and no drive.
  assign rd_access = BUS_RD && !BUS_WR && in_range;
  assign pop_req   = rd_access && in_data;

  // Soft reset fires on the edge of the BUS_WR cycle addressing 0x0.
  assign soft_rst  = BUS_WR && in_regs && (rel == REG_VERSION);

  // ---------------------------------------------------------------------------
  // Occupancy, push and pop qualification
  // ---------------------------------------------------------------------------
  logic [PW-1:0] count;
  logic [PW-1:0] count_next;
  logic          is_full;
  logic          is_empty;
  logic          push;
  logic          pop;

  assign count    = wr_ptr - rd_ptr;
  assign is_full  = (count == DEPTH_W);
  assign is_empty = (count == '0);

  // Soft reset discards a word arriving in the same cycle.
  assign push = FIFO_WRITE && !is_full && !soft_rst;
  // Popping an empty FIFO is a harmless underflow: it returns 0 and leaves
  // the pointers alone.
  assign pop  = pop_req && !is_empty;

  assign count_next = count + {{(PW-1){1'b0}}, push} - {{(PW-1){1'b0}}, pop};

  // ---------------------------------------------------------------------------
  // Overflow counter (optional)
  // ---------------------------------------------------------------------------
  logic [31:0] ovf_val;

`ifdef BUS_STREAM_FIFO_OVF_CNT_EN
  logic [31:0] ovf_cnt;
  logic        drop;

  // A drop is a valid stream word refused because the FIFO is full; the
  // word swallowed by a soft reset does not count.
  assign drop = FIFO_WRITE && is_full && !soft_rst;

  // Count dropped words, saturating at all-ones; both resets clear it.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST || soft_rst) begin
      ovf_cnt <= '0;
    end else if (drop && (ovf_cnt != '1)) begin
      ovf_cnt <= ovf_cnt + 32'd1;
    end
  end

  assign ovf_val = ovf_cnt;
`else
  assign ovf_val = '0;
`endif

  // ---------------------------------------------------------------------------
  // Register read mux
  // ---------------------------------------------------------------------------
  logic [31:0] reg_rdata;

  // Select the register value for a read below the data window.
  always_comb begin
    reg_rdata = '0;
    if (rel == REG_VERSION) begin
      reg_rdata = {24'b0, VERSION};
    end else if (rel == REG_COUNT) begin
      reg_rdata = {{(32-PW){1'b0}}, count};
    end else if (rel == REG_OVF) begin
      reg_rdata = ovf_val;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------

  // Write accepted stream words into the RAM (no reset on the array itself).
  always_ff @(posedge BUS_CLK) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= FIFO_DATA;
    end
  end

  // Advance the pointers; hard and soft reset both return them to zero.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST || soft_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Register the flags from the occupancy after this cycle's push and pop.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST || soft_rst) begin
      FIFO_FULL  <= 1'b0;
      FIFO_EMPTY <= 1'b1;
    end else begin
      FIFO_FULL  <= (count_next == DEPTH_W);
      FIFO_EMPTY <= (count_next == '0);
    end
  end

  // Capture read data one cycle after the BUS_RD cycle; the value holds
  // until the next in-range read replaces it.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      rd_data <= '0;
      drive_q <= 1'b0;
    end else begin
      drive_q <= rd_access;
      if (rd_access) begin
        if (in_data) begin
          rd_data <= pop ? mem[rd_ptr[AW-1:0]] : 32'h0;
        end else begin
          rd_data <= reg_rdata;
        end
      end
    end
  end

  // Drive the shared bus only in the cycle after a read, and never while
  // the master is writing.
  assign BUS_DATA = (drive_q && !BUS_WR) ? rd_data : 32'hzzzz_zzzz;

endmodule
